uart_rx_oversampled: RTL and testbench

- Parametrised next-generation UART receiver running entirely on sysclk; no separately generated baud clock.
- Internal tick divider provides OVERSAMPLE ticks per bit.
- Majority-vote samples each bit at mid-bit; validates start bit and stop bit.
- Delivers each word over a valid/ready handshake with framing-error and overrun reporting.
- Sits between the board RXD pin and the CPU's UART peripheral registers.

---
 rtl/uart_rx_oversampled.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver on sysclk with 3-sample majority vote and valid/ready delivery.
// Optional parity stage: define UART_RX_PARITY_EN (add UART_RX_PARITY_ODD for odd parity).
module uart_rx_oversampled #(
  parameter int DIV        = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 uart_rxd,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int M  = OVERSAMPLE / 2;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] T_LO     = TW'(M - 1);
  localparam logic [TW-1:0] T_MID    = TW'(M);
  localparam logic [TW-1:0] T_HI     = TW'(M + 1);
  localparam logic [TW-1:0] T_END    = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BITS_N   = BW'(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    LINE_BREAK
  } state_t;

  state_t               state;
  logic                 sync1;
  logic                 rxs;
  logic [DW-1:0]        div_cnt;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0]           samp;
  logic                 tick;
  logic                 vote_pt;
  logic                 bit_end;
  logic                 voted;
  logic                 par_mismatch;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`endif

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_rxd;
      rxs   <= sync1;
    end
  end

  always_comb begin
    tick    = (div_cnt == DIV_LAST);
    vote_pt = tick && (tcnt == T_HI);
    bit_end = tick && (tcnt == T_END);
    voted   = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);
`ifdef UART_RX_PARITY_EN
 `ifdef UART_RX_PARITY_ODD
    par_mismatch = ~(^shreg ^ par_bit);
 `else
    par_mismatch = ^shreg ^ par_bit;
 `endif
`else
    par_mismatch = 1'b0;
`endif
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      tcnt       <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      samp       <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;

      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      // Divider and tick counter stay cleared in IDLE so bit timing starts at the start edge
      if (state == IDLE) begin
        div_cnt <= '0;
        tcnt    <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) tcnt <= (tcnt == T_END) ? '0 : tcnt + 1'b1;
        if (tick && tcnt == T_LO)  samp[0] <= rxs;
        if (tick && tcnt == T_MID) samp[1] <= rxs;
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            state   <= START;
            busy    <= 1'b1;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (vote_pt && voted) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bit_end) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (vote_pt) begin
            shreg   <= {voted, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (bit_end && bit_cnt == BITS_N) begin
`ifdef UART_RX_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (vote_pt) par_bit <= voted;
          if (bit_end) state <= STOP;
        end
`endif
        STOP: begin
          if (vote_pt) begin
            if (voted) begin
              // Delivery overrides a same-cycle handshake clear, so valid stays up with new data
              rx_data    <= shreg;
              rx_valid   <= 1'b1;
              parity_err <= par_mismatch;
              if (rx_valid && !rx_ready) overrun <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= LINE_BREAK;
            end
          end
        end
        LINE_BREAK: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: driver queues expected words, monitor checks deliveries.
module tb_uart_rx_oversampled;

  localparam int DIV = 4;
  localparam int OVS = 16;
  localparam int DB  = 8;
  localparam int BIT = DIV * OVS;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic          sysclk;
  logic          reset;
  logic          uart_rxd;
  logic          rx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;
  logic          busy;

  typedef struct {
    logic [DB-1:0] data;
    logic          perr;
    logic          ovr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   fe_count = 0;
  int   cyc_n = 0;
  int   valid_rise_cyc = 0;
  int   edge_cyc = 0;
  logic prev_valid = 1'b0;

  uart_rx_oversampled #(.DIV(DIV), .OVERSAMPLE(OVS), .DATA_BITS(DB)) dut (
    .sysclk(sysclk), .reset(reset), .uart_rxd(uart_rxd), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun), .busy(busy)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc_n++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Monitor: every accepted word is popped from the scoreboard and compared
  initial begin
    exp_t e;
    forever begin
      @(negedge sysclk);
      if (reset) begin
        if (frame_err) fe_count++;
        if (rx_valid && !prev_valid) valid_rise_cyc = cyc_n;
        if (rx_valid && rx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word got=%0h expected=none", rx_data);
          end else begin
            e = exp_q.pop_front();
            chk("rx_data", 32'(rx_data), 32'(e.data));
            chk("parity_err", 32'(parity_err), 32'(e.perr));
            chk("overrun_at_accept", 32'(overrun), 32'(e.ovr));
          end
        end
      end
      prev_valid = rx_valid;
    end
  end

  task automatic cyc();
    @(posedge sysclk);
    #1;
  endtask

  task automatic line_bits(input logic b, input int n);
    uart_rxd = b;
    repeat (n) cyc();
  endtask

  function automatic logic good_parity(input logic [DB-1:0] d);
`ifdef UART_RX_PARITY_ODD
    return ~(^d);
`else
    return ^d;
`endif
  endfunction

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_v,
                            input logic par_flip, input int spike_bit);
    edge_cyc = cyc_n;
    line_bits(1'b0, BIT);
    for (int i = 0; i < DB; i++) begin
      if (i == spike_bit) begin
        line_bits(d[i], 38);
        line_bits(1'b0, 4);
        line_bits(d[i], BIT - 42);
      end else begin
        line_bits(d[i], BIT);
      end
    end
    if (P == 1) line_bits(good_parity(d) ^ par_flip, BIT);
    line_bits(stop_v, BIT);
  endtask

  task automatic push(input logic [DB-1:0] d, input logic perr, input logic ovr);
    exp_t e;
    e.data = d;
    e.perr = perr;
    e.ovr  = ovr;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 4000) begin
      cyc();
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int fe0;
    int lat;
    int nom;
    logic [DB-1:0] d;
    logic pf;
    reset    = 1'b0;
    uart_rxd = 1'b1;
    rx_ready = 1'b1;
    repeat (3) cyc();
    chk("reset_rx_valid", 32'(rx_valid), 0);
    chk("reset_rx_data", 32'(rx_data), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_frame_err", 32'(frame_err), 0);
    chk("reset_overrun", 32'(overrun), 0);
    chk("reset_parity_err", 32'(parity_err), 0);
    reset = 1'b1;
    repeat (5) cyc();

    // Basic frame and latency
    fe0 = fe_count;
    push(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    wait_idle("a5_idle");
    lat = valid_rise_cyc - edge_cyc;
    nom = (1 + DB + P) * BIT + BIT / 2 + 3;
    chk("a5_latency_window", 32'((lat >= nom - 32) && (lat <= nom + 32)), 1);
    chk("a5_no_frame_err", 32'(fe_count - fe0), 0);
    chk("a5_overrun", 32'(overrun), 0);

    // Short glitch is a false start
    fe0 = fe_count;
    line_bits(1'b0, 20);
    line_bits(1'b1, 80);
    chk("glitch_busy", 32'(busy), 0);
    chk("glitch_valid", 32'(rx_valid), 0);
    chk("glitch_fe", 32'(fe_count - fe0), 0);

    // Bad stop bit followed by a long break
    fe0 = fe_count;
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    line_bits(1'b0, 300);
    chk("break_busy", 32'(busy), 1);
    chk("break_single_fe", 32'(fe_count - fe0), 1);
    chk("break_valid", 32'(rx_valid), 0);
    line_bits(1'b1, 10);
    wait_idle("break_idle");

    // Back-to-back frames with no consumer -> overrun
    rx_ready = 1'b0;
    push(8'h22, 1'b0, 1'b1);
    send_frame(8'h11, 1'b1, 1'b0, -1);
    chk("ovr_first_valid", 32'(rx_valid), 1);
    chk("ovr_first_data", 32'(rx_data), 32'h11);
    chk("ovr_first_flag", 32'(overrun), 0);
    send_frame(8'h22, 1'b1, 1'b0, -1);
    chk("ovr_valid", 32'(rx_valid), 1);
    chk("ovr_data", 32'(rx_data), 32'h22);
    chk("ovr_flag", 32'(overrun), 1);
    rx_ready = 1'b1;
    cyc();
    rx_ready = 1'b0;
    chk("ovr_cleared_valid", 32'(rx_valid), 0);
    chk("ovr_cleared_flag", 32'(overrun), 0);
    rx_ready = 1'b1;
    line_bits(1'b1, 20);

    // One-sample spike mid data bit 3 is voted out
    push(8'hFF, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 3);
    wait_idle("spike_idle");

`ifdef UART_RX_PARITY_EN
    push(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, -1);
    push(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0, -1);
    wait_idle("parity_idle");
`endif

    // Reset mid-frame aborts the word
    line_bits(1'b0, 200);
    reset = 1'b0;
    cyc();
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_valid", 32'(rx_valid), 0);
    uart_rxd = 1'b1;
    cyc();
    reset = 1'b1;
    repeat (5) cyc();
    chk("midreset_after_busy", 32'(busy), 0);

    // Randomized frames, including back-to-back
    for (int k = 0; k < 24; k++) begin
      d  = DB'($urandom);
      pf = (P == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      push(d, pf, 1'b0);
      send_frame(d, 1'b1, pf, -1);
      line_bits(1'b1, $urandom_range(0, 40));
    end
    wait_idle("random_idle");
    repeat (10) cyc();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
